// File: rtl/counter_pkg.sv
// Shared definitions for the wrap counter and its compare/interrupt stage.
// Holds the compare-channel state encoding and the default count width.
package counter_pkg;

  // Default width of the upstream count and of every compare value.
  localparam int COUNT_W = 32;

  typedef enum logic [1:0] {
    CMP_IDLE,
    CMP_ARMED,
    CMP_PENDING
  } cmp_state_t;

endpackage

// File: rtl/match_edge_det.sv
// Equality compare between a count and a compare value, with a registered
// copy of the result so that only the first cycle of a match is reported.
// A count that stalls on the compare value (upstream held in reset) thus
// produces a single event. Reusable for additional compare channels.
//
// Ports:
//   clk          clock
//   rst          asynchronous active-high reset
//   value_i      count being watched
//   cmp_i        compare value
//   match_edge_o high for one cycle when value_i first equals cmp_i
module match_edge_det
  import counter_pkg::*;
#(
  parameter int WIDTH = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value_i,
  input  logic [WIDTH-1:0] cmp_i,
  output logic             match_edge_o
);

  logic match;
  logic match_q;

  assign match = (value_i == cmp_i);

  // Remember last cycle's compare result to detect the rising edge of match.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b0;
    end else begin
      match_q <= match;
    end
  end

  assign match_edge_o = match && !match_q;

endmodule

// File: rtl/counter_cmp_irq.sv
// Compare/interrupt stage placed after the free-running wrap counter.
// Software loads a compare value through a valid/ready handshake. When the
// count reaches it, a level interrupt is raised and held until acknowledged.
// A one-shot compare returns to idle on ack; a periodic one re-arms.
//
// Ports:
//   clk, rst      clock and asynchronous active-high reset
//   q             count from the upstream counter
//   cmp_valid     compare write request
//   cmp_data      compare value (values above MAX_VALUE are rejected)
//   cmp_periodic  1 = re-arm after ack, 0 = one-shot
//   cmp_ready     write accepted when high together with cmp_valid (IDLE only)
//   disarm        cancel an armed or pending compare
//   irq           level interrupt
//   irq_ack       interrupt acknowledge
//   armed         high while ARMED or PENDING
//   cmp_err       one-cycle pulse after a rejected write
//   overrun_cnt   saturating count of matches missed while PENDING
//
// Build option: define CMP_OVERRUN_CNT_EN to add the OVF_W parameter and the
// overrun_cnt port. Without it, overruns are silently dropped.
module counter_cmp_irq
  import counter_pkg::*;
#(
  parameter int WIDTH     = COUNT_W,
  parameter int MAX_VALUE = 10000
`ifdef CMP_OVERRUN_CNT_EN
  ,
  parameter int OVF_W     = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q,
  input  logic             cmp_valid,
  input  logic [WIDTH-1:0] cmp_data,
  input  logic             cmp_periodic,
  output logic             cmp_ready,
  input  logic             disarm,
  output logic             irq,
  input  logic             irq_ack,
  output logic             armed,
  output logic             cmp_err
`ifdef CMP_OVERRUN_CNT_EN
  ,
  output logic [OVF_W-1:0] overrun_cnt
`endif
);

  localparam logic [WIDTH-1:0] MaxValue = WIDTH'(MAX_VALUE);

  cmp_state_t       state_q, state_d;
  logic [WIDTH-1:0] cmp_reg_q, cmp_reg_d;
  logic             periodic_q, periodic_d;
  logic             cmp_err_q, cmp_err_d;
  logic             match_edge;
  logic             accept_write;

  match_edge_det #(
    .WIDTH(WIDTH)
  ) u_match (
    .clk         (clk),
    .rst         (rst),
    .value_i     (q),
    .cmp_i       (cmp_reg_q),
    .match_edge_o(match_edge)
  );

  // Writes are only taken in IDLE, and only legal values arm the channel.
  assign accept_write = (state_q == CMP_IDLE) && cmp_valid && (cmp_data <= MaxValue);

  // Next-state logic. disarm outranks both irq_ack and a fresh match.
  always_comb begin
    state_d    = state_q;
    cmp_reg_d  = cmp_reg_q;
    periodic_d = periodic_q;
    cmp_err_d  = 1'b0;
    case (state_q)
      CMP_IDLE: begin
        if (cmp_valid) begin
          if (cmp_data > MaxValue) begin
            cmp_err_d = 1'b1;
          end else begin
            cmp_reg_d  = cmp_data;
            periodic_d = cmp_periodic;
            state_d    = CMP_ARMED;
          end
        end
      end
      CMP_ARMED: begin
        if (disarm) begin
          state_d = CMP_IDLE;
        end else if (match_edge) begin
          state_d = CMP_PENDING;
        end
      end
      CMP_PENDING: begin
        if (disarm) begin
          state_d = CMP_IDLE;
        end else if (irq_ack) begin
          state_d = periodic_q ? CMP_ARMED : CMP_IDLE;
        end
      end
      default: state_d = CMP_IDLE;
    endcase
  end

  // Channel state and latched compare configuration.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CMP_IDLE;
      cmp_reg_q  <= '0;
      periodic_q <= 1'b0;
      cmp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmp_reg_q  <= cmp_reg_d;
      periodic_q <= periodic_d;
      cmp_err_q  <= cmp_err_d;
    end
  end

  assign cmp_ready = (state_q == CMP_IDLE);
  assign irq       = (state_q == CMP_PENDING);
  assign armed     = (state_q != CMP_IDLE);
  assign cmp_err   = cmp_err_q;

`ifdef CMP_OVERRUN_CNT_EN
  logic             overrun;
  logic [OVF_W-1:0] ovf_q, ovf_d;

  // A match while PENDING is a missed event, unless disarm wins that cycle.
  assign overrun = (state_q == CMP_PENDING) && !disarm && match_edge;

  // Saturating overrun count, restarted by each accepted write.
  always_comb begin
    ovf_d = ovf_q;
    if (accept_write) begin
      ovf_d = '0;
    end else if (overrun && (ovf_q != '1)) begin
      ovf_d = ovf_q + OVF_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overrun_cnt = ovf_q;
`else
  logic unused_accept;
  assign unused_accept = accept_write;
`endif

endmodule

// File: tb/tb_counter_cmp_irq.sv
// Self-checking bench for counter_cmp_irq. The bench plays the upstream wrap
// counter (MAX_VALUE = 9) and keeps an event-level model of the compare
// channel: "armed", "pending", the latched compare, and the missed-match
// count, updated once per clock from the rules of the block.
module tb_counter_cmp_irq;

  localparam int W    = 32;
  localparam int MAXV = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  q;
  logic          cmp_valid;
  logic [W-1:0]  cmp_data;
  logic          cmp_periodic;
  logic          cmp_ready;
  logic          disarm;
  logic          irq;
  logic          irq_ack;
  logic          armed;
  logic          cmp_err;
`ifdef CMP_OVERRUN_CNT_EN
  logic [7:0]    overrun_cnt;
`endif

  counter_cmp_irq #(
    .WIDTH    (W),
    .MAX_VALUE(MAXV)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .q           (q),
    .cmp_valid   (cmp_valid),
    .cmp_data    (cmp_data),
    .cmp_periodic(cmp_periodic),
    .cmp_ready   (cmp_ready),
    .disarm      (disarm),
    .irq         (irq),
    .irq_ack     (irq_ack),
    .armed       (armed),
    .cmp_err     (cmp_err)
`ifdef CMP_OVERRUN_CNT_EN
    ,
    .overrun_cnt (overrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model of the channel and of the upstream counter.
  int unsigned qVal;
  int unsigned mCmp;
  int unsigned mOvf;
  bit          mArmed, mPending, mPer, mPrevMatch, mErr;
  int          pendCycles;
  int          holdLeft;

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string where);
    checkValue({where, ".irq"}, 32'(irq), 32'(mPending));
    checkValue({where, ".armed"}, 32'(armed), 32'(mArmed));
    checkValue({where, ".cmp_ready"}, 32'(cmp_ready), 32'(!mArmed));
    checkValue({where, ".cmp_err"}, 32'(cmp_err), 32'(mErr));
`ifdef CMP_OVERRUN_CNT_EN
    checkValue({where, ".overrun_cnt"}, 32'(overrun_cnt), mOvf);
`endif
  endtask

  task automatic modelReset();
    mArmed     = 1'b0;
    mPending   = 1'b0;
    mPer       = 1'b0;
    mPrevMatch = 1'b0;
    mErr       = 1'b0;
    mCmp       = 0;
    mOvf       = 0;
    pendCycles = 0;
  endtask

  // One clock: drive at the falling edge, advance the model at the rising
  // edge, then compare just after it.
  task automatic applyStimulus(input bit v, input int unsigned d, input bit p,
                               input bit dis, input bit ack, input bit hold,
                               input string where);
    bit matchNow, eventNow;
    @(negedge clk);
    cmp_valid    = v;
    cmp_data     = d;
    cmp_periodic = p;
    disarm       = dis;
    irq_ack      = ack;
    q            = qVal;
    @(posedge clk);
    matchNow   = (qVal == mCmp);
    eventNow   = matchNow && !mPrevMatch;
    mPrevMatch = matchNow;
    mErr       = 1'b0;
    if (!mArmed) begin
      if (v) begin
        if (d > MAXV) begin
          mErr = 1'b1;
        end else begin
          mCmp    = d;
          mPer    = p;
          mArmed  = 1'b1;
          mOvf    = 0;
        end
      end
    end else if (dis) begin
      mArmed   = 1'b0;
      mPending = 1'b0;
    end else if (!mPending) begin
      if (eventNow) mPending = 1'b1;
    end else begin
      if (eventNow && mOvf < 255) mOvf++;
      if (ack) begin
        mPending = 1'b0;
        if (!mPer) mArmed = 1'b0;
      end
    end
    pendCycles = mPending ? pendCycles + 1 : 0;
    qVal = hold ? 0 : ((qVal == MAXV) ? 0 : qVal + 1);
    #1;
    checkOutput(where);
  endtask

  task automatic idle(input int n, input string where);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, where);
  endtask

  task automatic waitPending(input string where);
    for (int i = 0; i < 30 && !mPending; i++) applyStimulus(0, 0, 0, 0, 0, 0, where);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; q = '0; cmp_valid = 0; cmp_data = '0;
    cmp_periodic = 0; disarm = 0; irq_ack = 0;
    qVal = 0; holdLeft = 0;
    modelReset();
    #1;
    checkOutput("reset");
    @(negedge clk);
    rst = 1'b0;

    // One-shot compare at 5: irq the cycle after q==5, held until ack.
    $display("[TB] one-shot cmp=5");
    applyStimulus(1, 5, 0, 0, 0, 0, "os.write");
    waitPending("os.wait");
    idle(2, "os.hold");
    applyStimulus(0, 0, 0, 0, 1, 0, "os.ack");
    idle(14, "os.after");

    // Periodic compare at 3, acknowledged two cycles into each interrupt.
    $display("[TB] periodic cmp=3 with ack");
    applyStimulus(1, 3, 1, 0, 0, 0, "per.write");
    for (int i = 0; i < 35; i++)
      applyStimulus(0, 0, 0, 0, (mPending && pendCycles == 2), 0, "per.run");
    applyStimulus(0, 0, 0, 1, 0, 0, "per.disarm");

    // Periodic compare at 3 never acknowledged: overruns accumulate.
    $display("[TB] periodic cmp=3 without ack");
    applyStimulus(1, 3, 1, 0, 0, 0, "ovf.write");
    waitPending("ovf.wait");
    idle(25, "ovf.run");
`ifdef CMP_OVERRUN_CNT_EN
    checkValue("ovf.two", 32'(overrun_cnt), 32'd2);
    idle(2600, "ovf.long");
    checkValue("ovf.saturate", 32'(overrun_cnt), 32'd255);
`endif
    applyStimulus(0, 0, 0, 1, 0, 0, "ovf.disarm");

    // Out-of-range compare value is rejected with a one-cycle error.
    $display("[TB] reject cmp=10");
    applyStimulus(1, 10, 0, 0, 0, 0, "err.write");
    idle(15, "err.after");
    applyStimulus(1, MAXV, 0, 0, 0, 0, "max.write");
    waitPending("max.wait");
    applyStimulus(0, 0, 0, 0, 1, 0, "max.ack");

    // disarm + irq_ack + a new match in one cycle while pending.
    $display("[TB] disarm priority");
    applyStimulus(1, 3, 1, 0, 0, 0, "pri.write");
    waitPending("pri.wait");
    for (int i = 0; i < 12 && qVal != 3; i++) applyStimulus(0, 0, 0, 0, 0, 0, "pri.align");
    applyStimulus(0, 0, 0, 1, 1, 0, "pri.all");
    idle(3, "pri.after");

    // Asynchronous reset between clock edges while pending.
    $display("[TB] async reset mid-pending");
    applyStimulus(1, 3, 1, 0, 0, 0, "arst.write");
    waitPending("arst.wait");
    idle(12, "arst.run");
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    modelReset();
    qVal = 0;
    q    = '0;
    checkOutput("arst");
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic including stalls of the upstream counter at 0.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      if (holdLeft == 0 && $urandom_range(0, 29) == 0) holdLeft = $urandom_range(1, 4);
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 12), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, holdLeft > 0, "rand");
      if (holdLeft > 0) holdLeft--;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
